// File: rtl/ahfp_pkg.sv
// Shared constants for the ahfp floating-point datapath stages.
package ahfp_pkg;
   localparam int BIAS   = 127;
   localparam int MAN_W  = 23;
   localparam int EXPF_W = 8;
   localparam int PROD_W = 48;

   localparam logic [31:0]       QNAN    = 32'h7FC00000;
   localparam logic [EXPF_W-1:0] INF_EXP = 8'hFF;

   // Normalise/round/pack FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_NORM  = 2'd1;
   localparam logic [1:0] ST_ROUND = 2'd2;
   localparam logic [1:0] ST_PACK  = 2'd3;
endpackage

// File: rtl/ahfp_norm_round_if.sv
// Request/response bundle between the multiplier core and the norm/round stage.
interface ahfp_norm_round_if;
   import ahfp_pkg::*;
   logic              start;
   logic              sign_in;
   logic [8:0]        exp_sum;
   logic [PROD_W-1:0] man_prod;
   logic              in_zero;
   logic              in_inf;
   logic              in_nan;
   logic [31:0]       result;
   logic              done;
   logic              overflow;
   logic              underflow;
   logic              inexact;

   modport master (
      output start, sign_in, exp_sum, man_prod, in_zero, in_inf, in_nan,
      input  result, done, overflow, underflow, inexact
   );
   modport slave (
      input  start, sign_in, exp_sum, man_prod, in_zero, in_inf, in_nan,
      output result, done, overflow, underflow, inexact
   );
endinterface

// File: rtl/ahfp_round_rne.sv
// Round-to-nearest-even on a 24-bit mantissa with guard and sticky bits.
// A carry-out renormalises to 1.000..0; the caller bumps the exponent.
module ahfp_round_rne
   import ahfp_pkg::*;
(
   input  logic [MAN_W:0] m,
   input  logic           g,
   input  logic           s,
   output logic [MAN_W:0] m_rnd,
   output logic           cout,
   output logic           inexact
);
   logic             inc;
   logic [MAN_W+1:0] sum;

   assign inc     = g & (s | m[0]);
   assign sum     = {1'b0, m} + {{(MAN_W+1){1'b0}}, inc};
   assign cout    = sum[MAN_W+1];
   assign m_rnd   = cout ? {1'b1, {MAN_W{1'b0}}} : sum[MAN_W:0];
   assign inexact = g | s;
endmodule

// File: rtl/ahfp_norm_round.sv
// Multi-cycle normalise / round / pack stage after the FP multiplier.
// IDLE captures the raw product, NORM aligns it, ROUND applies RNE,
// PACK resolves specials and range and registers the IEEE single result.
module ahfp_norm_round
   import ahfp_pkg::*;
#(
   parameter int BIAS  = ahfp_pkg::BIAS,
   parameter int EXP_W = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_en,
   ahfp_norm_round_if.slave   bus
);
   localparam logic signed [EXP_W-1:0] BIAS_E  = EXP_W'(BIAS);
   localparam logic signed [EXP_W-1:0] BIAS_M1 = EXP_W'(BIAS - 1);
   localparam logic signed [EXP_W-1:0] E_MAX   = EXP_W'(255);
   localparam logic signed [EXP_W-1:0] E_ZERO  = '0;

   logic [1:0]              state;
   logic                    sign_r;
   logic [8:0]              exp_r;
   logic [PROD_W-1:0]       prod_r;
   logic                    zero_r, inf_r, nan_r;
   logic [MAN_W:0]          m_r;
   logic                    g_r, s_r, inx_r;
   logic signed [EXP_W-1:0] e_r;
   logic signed [EXP_W-1:0] e_base;

   logic [31:0]             result_r;
   logic                    done_r, ovf_r, unf_r, inexact_r;

   logic [MAN_W:0]          m_rnd;
   logic                    rnd_cout, rnd_inx;

   // Exponent sum is unsigned 0..510; widen with a zero MSB before going signed
   assign e_base = EXP_W'({1'b0, exp_r});

   ahfp_round_rne u_rne (
      .m       (m_r),
      .g       (g_r),
      .s       (s_r),
      .m_rnd   (m_rnd),
      .cout    (rnd_cout),
      .inexact (rnd_inx)
   );

   // FSM and datapath registers; everything freezes while clk_en is low
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         sign_r    <= 1'b0;
         exp_r     <= '0;
         prod_r    <= '0;
         zero_r    <= 1'b0;
         inf_r     <= 1'b0;
         nan_r     <= 1'b0;
         m_r       <= '0;
         g_r       <= 1'b0;
         s_r       <= 1'b0;
         inx_r     <= 1'b0;
         e_r       <= '0;
         result_r  <= '0;
         done_r    <= 1'b0;
         ovf_r     <= 1'b0;
         unf_r     <= 1'b0;
         inexact_r <= 1'b0;
      end else if (clk_en) begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  sign_r <= bus.sign_in;
                  exp_r  <= bus.exp_sum;
                  prod_r <= bus.man_prod;
                  zero_r <= bus.in_zero;
                  inf_r  <= bus.in_inf;
                  nan_r  <= bus.in_nan;
                  state  <= ST_NORM;
               end
            end
            ST_NORM: begin
               // Product of two [1,2) mantissas lies in [1,4): at most one shift
               if (prod_r[47]) begin
                  m_r <= prod_r[47:24];
                  g_r <= prod_r[23];
                  s_r <= |prod_r[22:0];
                  e_r <= e_base - BIAS_M1;
               end else begin
                  m_r <= prod_r[46:23];
                  g_r <= prod_r[22];
                  s_r <= |prod_r[21:0];
                  e_r <= e_base - BIAS_E;
               end
               state <= ST_ROUND;
            end
            ST_ROUND: begin
               m_r   <= m_rnd;
               e_r   <= e_r + {{(EXP_W-1){1'b0}}, rnd_cout};
               inx_r <= rnd_inx;
               state <= ST_PACK;
            end
            default: begin
               ovf_r     <= 1'b0;
               unf_r     <= 1'b0;
               inexact_r <= 1'b0;
               if (nan_r) begin
                  result_r <= QNAN;
               end else if (inf_r) begin
                  result_r <= {sign_r, INF_EXP, {MAN_W{1'b0}}};
               end else if (zero_r || prod_r[47:46] == 2'b00) begin
                  result_r <= {sign_r, 31'h0};
               end else if (e_r >= E_MAX) begin
                  result_r  <= {sign_r, INF_EXP, {MAN_W{1'b0}}};
                  ovf_r     <= 1'b1;
                  inexact_r <= 1'b1;
               end else if (e_r <= E_ZERO) begin
                  result_r  <= {sign_r, 31'h0};
                  unf_r     <= 1'b1;
                  inexact_r <= 1'b1;
               end else begin
                  result_r  <= {sign_r, e_r[EXPF_W-1:0], m_r[MAN_W-1:0]};
                  inexact_r <= inx_r;
               end
               done_r <= 1'b1;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.result    = result_r;
   assign bus.done      = done_r;
   assign bus.overflow  = ovf_r;
   assign bus.underflow = unf_r;
   assign bus.inexact   = inexact_r;
endmodule

// File: tb/tb_ahfp_norm_round.sv
// Directed bench for ahfp_norm_round: vector table plus control sequences.
module tb_ahfp_norm_round;
   import ahfp_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic clk_en;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ahfp_norm_round_if bus ();

   ahfp_norm_round #(.BIAS(127), .EXP_W(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .bus    (bus)
   );

   typedef struct {
      logic        s;
      logic [8:0]  es;
      logic [47:0] mp;
      logic        z, i, n;
      logic [31:0] res;
      logic        ov, un, ix;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      bus.sign_in  = v.s;
      bus.exp_sum  = v.es;
      bus.man_prod = v.mp;
      bus.in_zero  = v.z;
      bus.in_inf   = v.i;
      bus.in_nan   = v.n;
   endtask

   // Issue one op, scramble inputs after acceptance, wait for done and check it
   task automatic run_vec(input vec_t v, input string name, input int lat, input bit stall);
      int n;
      bit seen;
      drive(v);
      bus.start = 1'b1;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         step();
         n++;
         if (n == 1) begin
            bus.start    = 1'b0;
            bus.man_prod = ~v.mp;
            bus.exp_sum  = ~v.es;
            bus.sign_in  = ~v.s;
            if (stall) clk_en = 1'b0;
         end
         if (stall && n == 4) clk_en = 1'b1;
         if (bus.done) seen = 1'b1;
      end
      chk({name, " latency"}, n, lat);
      chk({name, " result"}, bus.result, v.res);
      chk({name, " flags"}, {29'h0, bus.overflow, bus.underflow, bus.inexact},
          {29'h0, v.ov, v.un, v.ix});
      step();
      chk({name, " done pulse"}, {31'h0, bus.done}, 32'h0);
      chk({name, " result hold"}, bus.result, v.res);
   endtask

   initial begin
      int pulses;
      vecs[0]  = '{1'b0, 9'd255, 48'h600000000000, 1'b0, 1'b0, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 9'd254, 48'h900000000000, 1'b0, 1'b0, 1'b0, 32'h40100000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 9'd254, 48'h400000C00000, 1'b0, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 9'd254, 48'h400000400000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 9'd254, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 9'd400, 48'h600000000000, 1'b0, 1'b0, 1'b0, 32'hFF800000, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 9'd100, 48'h600000000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 9'd255, 48'h600000000000, 1'b0, 1'b0, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 9'd255, 48'h600000000000, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 9'd255, 48'h600000000000, 1'b0, 1'b1, 1'b0, 32'h7F800000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 9'd381, 48'h600000000000, 1'b0, 1'b0, 1'b0, 32'h7F400000, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 9'd382, 48'h600000000000, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 9'd128, 48'h600000000000, 1'b0, 1'b0, 1'b0, 32'h00C00000, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 9'd127, 48'h600000000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 9'd255, 48'h000000000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 9'd255, 48'h600000000000, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 9'd254, 48'h400000400001, 1'b0, 1'b0, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b1};

      // Reset must act even with clk_en low
      reset     = 1'b1;
      clk_en    = 1'b0;
      bus.start = 1'b0;
      drive(vecs[0]);
      step();
      step();
      reset  = 1'b0;
      clk_en = 1'b1;
      chk("reset result", bus.result, 32'h0);
      chk("reset done/flags", {28'h0, bus.done, bus.overflow, bus.underflow, bus.inexact}, 32'h0);

      for (int k = 0; k < NV; k++)
         run_vec(vecs[k], $sformatf("v%0d", k), 4, 1'b0);

      // Three disabled cycles in NORM stretch latency to 7
      run_vec(vecs[1], "stall", 7, 1'b1);

      // Reset while in ROUND abandons the op
      drive(vecs[0]);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst-mid result", bus.result, 32'h0);
      chk("rst-mid done/flags", {28'h0, bus.done, bus.overflow, bus.underflow, bus.inexact}, 32'h0);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (bus.done) pulses++;
      end
      chk("rst-mid no done", pulses, 0);
      run_vec(vecs[2], "after-rst", 4, 1'b0);

      // Start held high: one op every 4 cycles
      drive(vecs[4]);
      bus.start = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (bus.done) begin
            pulses++;
            chk("b2b phase", k % 4, 0);
            chk("b2b result", bus.result, vecs[4].res);
         end
      end
      bus.start = 1'b0;
      chk("b2b count", pulses, 4);
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
